// File: rtl/mk14_display_scanner.sv
// Display-refresh engine: periodically takes the shared BRAM port from the core and
// burst-reads N_DIGITS bytes into a display shadow register. Optional DISPLAY_CHANGE_DETECT_EN adds 'changed'.
module mk14_display_scanner #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    N_DIGITS       = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0D00,
    parameter int                    REFRESH_CYCLES = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           core_busy,
    output logic                           core_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_read_data,
    output logic [N_DIGITS*DATA_WIDTH-1:0] display,
    output logic                           frame_done,
`ifdef DISPLAY_CHANGE_DETECT_EN
    output logic                           changed,
`endif
    output logic [2:0]                     state_dbg
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_ARM  = 3'd2,
        ST_SCAN = 3'd3,
        ST_TAIL = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] period_cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cap_idx;
    logic             capture;
    logic             core_en_nx;
    logic             done_nx;

    assign state_dbg = state;
    // Index holds at its last value outside SCAN, so the address does too.
    assign mem_addr  = BASE_ADDR + ADDR_WIDTH'(idx);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT: state_nx = ST_SCAN;
            ST_IDLE: if (period_cnt == LAST_CNT) state_nx = ST_ARM;
            ST_ARM:  if (!core_busy) state_nx = ST_SCAN;
            ST_SCAN: if (idx == LAST_IDX) state_nx = ST_TAIL;
            ST_TAIL: state_nx = ST_IDLE;
            default: state_nx = ST_INIT;
        endcase
    end

    // Read data lags the address by one cycle, so digit idx-1 lands during SCAN and the last in TAIL.
    always_comb begin
        core_en_nx = (state_nx == ST_IDLE) || (state_nx == ST_ARM);
        done_nx    = (state == ST_TAIL);
        capture    = ((state == ST_SCAN) && (idx != '0)) || (state == ST_TAIL);
        cap_idx    = (state == ST_TAIL) ? idx : IDX_W'(idx - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_en    <= 1'b0;
            frame_done <= 1'b0;
            period_cnt <= '0;
            idx        <= '0;
            display    <= '0;
        end else begin
            core_en    <= core_en_nx;
            frame_done <= done_nx;
            if (state == ST_IDLE)
                period_cnt <= (period_cnt == LAST_CNT) ? '0 : CNT_W'(period_cnt + 1'b1);
            if ((state == ST_ARM) && (state_nx == ST_SCAN))
                idx <= '0;
            else if ((state == ST_SCAN) && (idx != LAST_IDX))
                idx <= IDX_W'(idx + 1'b1);
            for (int i = 0; i < N_DIGITS; i++) begin
                if (capture && (cap_idx == IDX_W'(i)))
                    display[DATA_WIDTH*i +: DATA_WIDTH] <= mem_read_data;
            end
        end
    end

`ifdef DISPLAY_CHANGE_DETECT_EN
    logic [DATA_WIDTH-1:0] cap_old;
    logic                  cap_differs;
    logic                  diff_flag;

    always_comb begin
        cap_old = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cap_idx == IDX_W'(i))
                cap_old = display[DATA_WIDTH*i +: DATA_WIDTH];
        end
        cap_differs = capture && (cap_old != mem_read_data);
    end

    // Sticky compare flag spans the whole burst; cleared as the burst begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_flag <= 1'b0;
            changed   <= 1'b0;
        end else begin
            if ((state_nx == ST_SCAN) && (state != ST_SCAN))
                diff_flag <= 1'b0;
            else if (cap_differs)
                diff_flag <= 1'b1;
            changed <= (state == ST_TAIL) && (diff_flag || cap_differs);
        end
    end
`endif

endmodule

// File: tb/tb_mk14_display_scanner.sv
// Bench for mk14_display_scanner: two instances (base 0D00 and wrapping base FFFE),
// behavioural memory, frame-level reference expectations.
module tb_mk14_display_scanner;

    localparam int          N  = 4;
    localparam int          R  = 10;
    localparam logic [15:0] B0 = 16'h0D00;
    localparam logic [15:0] B1 = 16'hFFFE;
    localparam int          BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_busy = 1'b0;
    logic        core_en0, core_en1;
    logic [15:0] addr0, addr1;
    logic [7:0]  rd0 = 8'h00, rd1 = 8'h00;
    logic [31:0] disp0, disp1;
    logic        fd0, fd1;
    logic [2:0]  st0, st1;
`ifdef DISPLAY_CHANGE_DETECT_EN
    logic        chg0, chg1;
`endif

    logic [7:0] mem0 [4];
    logic [7:0] mem1 [4];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mk14_display_scanner #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .N_DIGITS(N),
                           .BASE_ADDR(B0), .REFRESH_CYCLES(R)) u_dut (
        .clk(clk), .rst_n(rst_n), .core_busy(core_busy), .core_en(core_en0),
        .mem_addr(addr0), .mem_read_data(rd0), .display(disp0), .frame_done(fd0),
`ifdef DISPLAY_CHANGE_DETECT_EN
        .changed(chg0),
`endif
        .state_dbg(st0));

    mk14_display_scanner #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .N_DIGITS(N),
                           .BASE_ADDR(B1), .REFRESH_CYCLES(R)) u_wrap (
        .clk(clk), .rst_n(rst_n), .core_busy(core_busy), .core_en(core_en1),
        .mem_addr(addr1), .mem_read_data(rd1), .display(disp1), .frame_done(fd1),
`ifdef DISPLAY_CHANGE_DETECT_EN
        .changed(chg1),
`endif
        .state_dbg(st1));

    // Memory: digit k of each instance lives at base+k (16-bit wrap); elsewhere junk.
    function automatic logic [7:0] lookup(input logic [15:0] a, input logic [15:0] base,
                                          input logic [7:0] m [4]);
        logic [15:0] off;
        off = a - base;
        if (off < 16'd4) return m[off[1:0]];
        return 8'hEE;
    endfunction

    always @(posedge clk) begin
        rd0 <= lookup(addr0, B0, mem0);
        rd1 <= lookup(addr1, B1, mem1);
    end

    function automatic logic [31:0] pack(input logic [7:0] m [4]);
        logic [31:0] p;
        for (int k = 0; k < 4; k++) p[k*8 +: 8] = m[k];
        return p;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic randomize_mem0();
        for (int k = 0; k < 4; k++) mem0[k] = 8'($urandom_range(0, 255));
    endtask

    // Starts at a frame_done sample; returns at the next one. Busy is random where it
    // must be ignored, held for 'hold' ARM cycles, then released.
    task automatic observe_frame(input int hold, output int high, output int low,
                                 output int gap, output int addr_err,
                                 output logic [31:0] disp_pre);
        int s;
        logic [15:0] ea;
        s = 0; high = 1; low = 0; addr_err = 0; gap = -1; disp_pre = disp0;
        while (s < BUDGET) begin
            if (!core_en0)          core_busy = 1'($urandom_range(0, 1));
            else if (s < R)         core_busy = 1'($urandom_range(0, 1));
            else if (s < R + hold)  core_busy = 1'b1;
            else                    core_busy = 1'b0;
            step();
            s++;
            if (fd0) begin
                gap = s;
                break;
            end
            if (core_en0) begin
                if (low == 0) begin
                    high++;
                    disp_pre = disp0;
                end
            end else begin
                ea = B0 + 16'(low);
                if (low < N && addr0 !== ea) addr_err++;
                low++;
            end
        end
        core_busy = 1'b0;
    endtask

    // Called with rst_n low at a negedge; releases reset and follows the first frame.
    task automatic check_init_frame(input string tag);
        int low, k, aerr0, aerr1, s;
        logic [15:0] e0, e1;
        low = 1; aerr0 = 0; aerr1 = 0; s = 0;
        rst_n = 1'b1;
        while (s < BUDGET) begin
            core_busy = 1'($urandom_range(0, 1));
            step();
            s++;
            if (fd0) break;
            if (!core_en0) begin
                k = low - 1;
                e0 = B0 + 16'(k);
                e1 = B1 + 16'(k);
                if (k < N && addr0 !== e0) aerr0++;
                if (k < N && addr1 !== e1) aerr1++;
                low++;
            end
        end
        core_busy = 1'b0;
        n_cmp++;
        if (fd0 !== 1'b1) begin
            n_fail++; $display("FAIL %s_frame_done_timeout: got %b expected 1", tag, fd0);
        end
        n_cmp++;
        if (low !== N + 2) begin
            n_fail++; $display("FAIL %s_core_en_low_cycles: got %0d expected %0d", tag, low, N + 2);
        end
        n_cmp++;
        if (aerr0 !== 0) begin
            n_fail++; $display("FAIL %s_scan_addr: got %0d bad addresses expected 0", tag, aerr0);
        end
        n_cmp++;
        if (aerr1 !== 0) begin
            n_fail++; $display("FAIL %s_wrap_addr: got %0d bad addresses expected 0", tag, aerr1);
        end
        n_cmp++;
        if (disp0 !== pack(mem0)) begin
            n_fail++; $display("FAIL %s_display: got %h expected %h", tag, disp0, pack(mem0));
        end
        n_cmp++;
        if (disp1 !== pack(mem1)) begin
            n_fail++; $display("FAIL %s_wrap_display: got %h expected %h", tag, disp1, pack(mem1));
        end
        n_cmp++;
        if (core_en0 !== 1'b1 || fd1 !== 1'b1) begin
            n_fail++; $display("FAIL %s_release: got core_en=%b fd_wrap=%b expected 1 1", tag, core_en0, fd1);
        end
    endtask

    task automatic test_reset();
        mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; mem0[3] = 8'h44;
        for (int k = 0; k < 4; k++) mem1[k] = 8'($urandom_range(0, 255));
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (core_en0 !== 1'b0 || fd0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got core_en=%b frame_done=%b expected 0 0", core_en0, fd0);
        end
        n_cmp++;
        if (disp0 !== 32'h0 || disp1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_display: got %h/%h expected 0", disp0, disp1);
        end
        n_cmp++;
        if (addr0 !== B0 || addr1 !== B1) begin
            n_fail++; $display("FAIL reset_addr: got %h/%h expected %h/%h", addr0, addr1, B0, B1);
        end
        check_init_frame("init");
        n_cmp++;
        if (disp0 !== 32'h44332211) begin
            n_fail++; $display("FAIL init_known_pattern: got %h expected 44332211", disp0);
        end
    endtask

    task automatic test_steady();
        int high, low, gap, aerr;
        logic [31:0] pre, prev_exp;
        for (int f = 0; f < 3; f++) begin
            prev_exp = pack(mem0);
            randomize_mem0();
            observe_frame(0, high, low, gap, aerr, pre);
            n_cmp++;
            if (gap !== R + N + 2) begin
                n_fail++; $display("FAIL steady_period: got %0d expected %0d", gap, R + N + 2);
            end
            n_cmp++;
            if (high !== R + 1 || low !== N + 1) begin
                n_fail++; $display("FAIL steady_core_en: got high=%0d low=%0d expected %0d %0d", high, low, R + 1, N + 1);
            end
            n_cmp++;
            if (aerr !== 0) begin
                n_fail++; $display("FAIL steady_addr: got %0d bad addresses expected 0", aerr);
            end
            n_cmp++;
            if (pre !== prev_exp) begin
                n_fail++; $display("FAIL steady_display_hold: got %h expected %h", pre, prev_exp);
            end
            n_cmp++;
            if (disp0 !== pack(mem0)) begin
                n_fail++; $display("FAIL steady_display: got %h expected %h", disp0, pack(mem0));
            end
        end
        step();
        n_cmp++;
        if (fd0 !== 1'b0 || disp0 !== pack(mem0)) begin
            n_fail++; $display("FAIL steady_pulse_width: got fd=%b disp=%h expected 0 %h", fd0, disp0, pack(mem0));
        end
        // Realign to a frame_done sample for the next scenario.
        for (int s = 0; s < BUDGET && !fd0; s++) step();
    endtask

    task automatic test_arm_hold();
        int high, low, gap, aerr, hold;
        logic [31:0] pre;
        for (int f = 0; f < 3; f++) begin
            hold = (f == 0) ? 7 : $urandom_range(1, 5);
            randomize_mem0();
            observe_frame(hold, high, low, gap, aerr, pre);
            n_cmp++;
            if (high !== R + hold + 1) begin
                n_fail++; $display("FAIL arm_hold_high: got %0d expected %0d (hold %0d)", high, R + hold + 1, hold);
            end
            n_cmp++;
            if (low !== N + 1 || gap !== R + hold + N + 2) begin
                n_fail++; $display("FAIL arm_hold_frame: got low=%0d gap=%0d expected %0d %0d", low, gap, N + 1, R + hold + N + 2);
            end
            n_cmp++;
            if (aerr !== 0 || disp0 !== pack(mem0)) begin
                n_fail++; $display("FAIL arm_hold_data: got aerr=%0d disp=%h expected 0 %h", aerr, disp0, pack(mem0));
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int s;
        randomize_mem0();
        core_busy = 1'b0;
        s = 0;
        while (core_en0 && s < BUDGET) begin
            step();
            s++;
        end
        n_cmp++;
        if (core_en0 !== 1'b0) begin
            n_fail++; $display("FAIL midscan_reach_scan: got core_en=%b expected 0", core_en0);
        end
        step();
        step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (disp0 !== 32'h0 || disp1 !== 32'h0) begin
            n_fail++; $display("FAIL midscan_display_clear: got %h/%h expected 0", disp0, disp1);
        end
        n_cmp++;
        if (core_en0 !== 1'b0 || fd0 !== 1'b0 || addr0 !== B0) begin
            n_fail++; $display("FAIL midscan_reset_state: got en=%b fd=%b addr=%h expected 0 0 %h", core_en0, fd0, addr0, B0);
        end
        mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; mem0[3] = 8'h44;
        check_init_frame("midscan");
    endtask

`ifdef DISPLAY_CHANGE_DETECT_EN
    task automatic test_change_detect();
        int high, low, gap, aerr;
        logic [31:0] pre;
        mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; mem0[3] = 8'h44;
        observe_frame(0, high, low, gap, aerr, pre);
        mem0[2] = 8'h55;
        observe_frame(0, high, low, gap, aerr, pre);
        n_cmp++;
        if (chg0 !== 1'b1) begin
            n_fail++; $display("FAIL changed_on_edit: got %b expected 1", chg0);
        end
        observe_frame(0, high, low, gap, aerr, pre);
        n_cmp++;
        if (chg0 !== 1'b0) begin
            n_fail++; $display("FAIL changed_when_same: got %b expected 0", chg0);
        end
        step();
        n_cmp++;
        if (chg0 !== 1'b0) begin
            n_fail++; $display("FAIL changed_pulse_width: got %b expected 0", chg0);
        end
        for (int s = 0; s < BUDGET && !fd0; s++) step();
    endtask
`endif

    initial begin
        test_reset();
        test_steady();
        test_arm_hold();
`ifdef DISPLAY_CHANGE_DETECT_EN
        test_change_detect();
`endif
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
